// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port synchronous SRAM (1-cycle read latency) between a
// write requester and a read requester. Writes win arbitration so that reads
// always observe the most recent data. A starvation counter forces a read
// through after STARVE_LIMIT consecutive losses. Read data lands in a
// 2-entry response FIFO so that read-side backpressure never stalls the SRAM.
//
// Ports:
//   clk_i, rst_i                 clock (rising edge), synchronous active-high reset
//   wr_req_i / wr_gnt_o          write request / same-cycle grant
//   wr_addr_i, wr_be_i, wr_data_i  write word address, byte enables, data
//   rd_req_i / rd_gnt_o          read request / same-cycle grant
//   rd_addr_i                    read word address
//   rd_rvalid_o / rd_rready_i    read response handshake
//   rd_rdata_o                   read response data (FIFO head)
//   mem_req_o, mem_we_o          SRAM access strobe and write enable
//   mem_addr_o, mem_be_o, mem_wdata_o  SRAM address, byte enables, write data
//   mem_rdata_i                  SRAM read data, valid one cycle after a read
//
// Optional build macro:
//   MEM_ARB_ASSERT_EN  adds simulation-only protocol assertions. When it is
//                      undefined no checking logic is compiled in.
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_WIDTH   = 20,
    parameter int DATA_WIDTH   = 64,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,

    input  logic                    wr_req_i,
    output logic                    wr_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   wr_addr_i,
    input  logic [DATA_WIDTH/8-1:0] wr_be_i,
    input  logic [DATA_WIDTH-1:0]   wr_data_i,

    input  logic                    rd_req_i,
    output logic                    rd_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   rd_addr_i,
    output logic                    rd_rvalid_o,
    input  logic                    rd_rready_i,
    output logic [DATA_WIDTH-1:0]   rd_rdata_o,

    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [DATA_WIDTH/8-1:0] mem_be_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                  inflight_reg;
    logic [1:0]            count_reg;
    logic [1:0]            count_next;
    logic                  rd_ptr_reg;
    logic                  wr_ptr_reg;
    logic [DATA_WIDTH-1:0] fifo_mem [2];
    logic [STARVE_W-1:0]   starve_reg;
    logic [STARVE_W-1:0]   starve_next;

    logic       push;
    logic       pop;
    logic       rd_ok;
    logic       force_rd;
    logic [2:0] occupancy;

    // ------------------------------------------------------------------
    // Response side and read credit
    // ------------------------------------------------------------------
    assign rd_rvalid_o = !rst_i && (count_reg != 2'd0);
    assign rd_rdata_o  = fifo_mem[rd_ptr_reg];
    assign pop         = rd_rvalid_o && rd_rready_i;
    assign push        = inflight_reg;

    // A read in flight already owns a FIFO slot; a pop this cycle frees one,
    // which is what lets back-to-back reads stream at full rate.
    assign occupancy = {2'b00, inflight_reg} + {1'b0, count_reg} - {2'b00, pop};
    assign rd_ok     = occupancy < 3'd2;

    // ------------------------------------------------------------------
    // Arbitration (combinational, same-cycle grant)
    // ------------------------------------------------------------------
    assign force_rd = rd_req_i && rd_ok && (starve_reg == STARVE_MAX);
    assign wr_gnt_o = !rst_i && wr_req_i && !force_rd;
    assign rd_gnt_o = !rst_i && rd_req_i && rd_ok && (force_rd || !wr_req_i);

    // ------------------------------------------------------------------
    // Memory-side mux; idle cycles drive zeros
    // ------------------------------------------------------------------
    always_comb begin
        mem_req_o   = wr_gnt_o || rd_gnt_o;
        mem_we_o    = wr_gnt_o;
        mem_addr_o  = '0;
        mem_be_o    = '0;
        mem_wdata_o = '0;
        if (wr_gnt_o) begin
            mem_addr_o  = wr_addr_i;
            mem_be_o    = wr_be_i;
            mem_wdata_o = wr_data_i;
        end else if (rd_gnt_o) begin
            mem_addr_o  = rd_addr_i;
            mem_be_o    = {BE_WIDTH{1'b1}};
        end
    end

    // ------------------------------------------------------------------
    // Starvation counter: counts writes that beat an eligible read.
    // Cycles where the read is blocked by credit do not count as losses.
    // ------------------------------------------------------------------
    always_comb begin
        starve_next = starve_reg;
        if (rd_gnt_o) begin
            starve_next = '0;
        end else if (wr_gnt_o && rd_req_i && rd_ok && (starve_reg != STARVE_MAX)) begin
            starve_next = starve_reg + 1'b1;
        end
    end

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 2'd1;
            2'b01:   count_next = count_reg - 2'd1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            inflight_reg <= 1'b0;
            count_reg    <= 2'd0;
            rd_ptr_reg   <= 1'b0;
            wr_ptr_reg   <= 1'b0;
            starve_reg   <= '0;
        end else begin
            inflight_reg <= rd_gnt_o;
            count_reg    <= count_next;
            starve_reg   <= starve_next;
            if (push) begin
                wr_ptr_reg <= !wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= !rd_ptr_reg;
            end
        end
    end

    // FIFO storage needs no reset: entries are only visible once counted.
    // A read in flight during reset is dropped because the pointers and
    // count are cleared regardless of the write below.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
            always_ff @(posedge clk_i) begin
                if (push && (wr_ptr_reg == 1'(gi))) begin
                    fifo_mem[gi] <= mem_rdata_i;
                end
            end
        end
    endgenerate

`ifdef MEM_ARB_ASSERT_EN
    // Consecutive cycles an eligible read has lost so far.
    int unsigned rd_wait_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_wait_reg <= 0;
        end else if (rd_req_i && rd_ok && !rd_gnt_o) begin
            rd_wait_reg <= rd_wait_reg + 1;
        end else begin
            rd_wait_reg <= 0;
        end
    end

    a_one_grant: assert property (@(posedge clk_i) disable iff (rst_i)
        !(wr_gnt_o && rd_gnt_o))
        else $error("both grants high");

    a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i)
        push |-> (count_reg != 2'd2))
        else $error("response FIFO overflow");

    a_wr_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (wr_req_i && !wr_gnt_o) |=>
            ($stable(wr_addr_i) && $stable(wr_be_i) && $stable(wr_data_i)))
        else $error("write request changed before grant");

    a_rd_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (rd_req_i && !rd_gnt_o) |=> $stable(rd_addr_i))
        else $error("read request changed before grant");

    a_rdata_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (rd_rvalid_o && !rd_rready_i) |=> $stable(rd_rdata_o))
        else $error("read data changed under backpressure");

    a_no_starve: assert property (@(posedge clk_i) disable iff (rst_i)
        (rd_req_i && rd_ok && !rd_gnt_o) |-> (rd_wait_reg < STARVE_LIMIT))
        else $error("read starved");
`else
    // Protocol assertions are compiled only with MEM_ARB_ASSERT_EN.
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Scoreboard bench for mem_port_arbiter. Requester tasks drive the write and
// read ports; a behavioural SRAM answers the memory port. A negedge monitor
// keeps a reference model (word array, queue of outstanding read responses
// tagged with the cycle they become visible, and a loss counter) and compares
// grants, memory-side signals and the read response stream every cycle.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int AW = 20;
    localparam int DW = 64;
    localparam int BW = DW / 8;
    localparam int SL = 4;

    logic          clk;
    logic          rst;
    logic          wr_req, wr_gnt;
    logic [AW-1:0] wr_addr;
    logic [BW-1:0] wr_be;
    logic [DW-1:0] wr_data;
    logic          rd_req, rd_gnt;
    logic [AW-1:0] rd_addr;
    logic          rd_rvalid, rd_rready;
    logic [DW-1:0] rd_rdata;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [BW-1:0] mem_be;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    mem_port_arbiter #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .STARVE_LIMIT (SL)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .wr_req_i    (wr_req),
        .wr_gnt_o    (wr_gnt),
        .wr_addr_i   (wr_addr),
        .wr_be_i     (wr_be),
        .wr_data_i   (wr_data),
        .rd_req_i    (rd_req),
        .rd_gnt_o    (rd_gnt),
        .rd_addr_i   (rd_addr),
        .rd_rvalid_o (rd_rvalid),
        .rd_rready_i (rd_rready),
        .rd_rdata_o  (rd_rdata),
        .mem_req_o   (mem_req),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_be_o    (mem_be),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int gnt_count = 0;

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w,
                                            input logic [DW-1:0] new_w,
                                            input logic [BW-1:0] be);
        logic [DW-1:0] r;
        r = old_w;
        for (int b = 0; b < BW; b++) begin
            if (be[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    // Behavioural SRAM on the memory port (1-cycle read latency).
    logic [DW-1:0] sram [256];
    always @(posedge clk) begin
        if (mem_req) begin
            if (mem_we) sram[mem_addr[7:0]] <= merge(sram[mem_addr[7:0]], mem_wdata, mem_be);
            else        mem_rdata <= sram[mem_addr[7:0]];
        end
    end

    // Reference model.
    typedef struct {
        logic [DW-1:0] data;
        int            avail;
    } resp_t;

    logic [DW-1:0] ref_mem [256];
    resp_t         exp_q [$];
    int            starve_m = 0;

    always @(negedge clk) begin
        logic exp_valid, pop, ok, frc, ew, er;
        cyc++;
        if (rst) begin
            chk("rst_wr_gnt", wr_gnt, 0);
            chk("rst_rd_gnt", rd_gnt, 0);
            chk("rst_mem_req", mem_req, 0);
            chk("rst_mem_we", mem_we, 0);
            chk("rst_rvalid", rd_rvalid, 0);
            exp_q.delete();
            starve_m = 0;
        end else begin
            exp_valid = (exp_q.size() > 0) && (exp_q[0].avail <= cyc);
            chk("rvalid", rd_rvalid, exp_valid);
            if (exp_valid) chk("rdata", rd_rdata, exp_q[0].data);
            pop = exp_valid && rd_rready;
            ok  = (exp_q.size() - (pop ? 1 : 0)) < 2;
            frc = rd_req && ok && (starve_m == SL);
            ew  = wr_req && !frc;
            er  = rd_req && ok && !ew;
            chk("wr_gnt", wr_gnt, ew);
            chk("rd_gnt", rd_gnt, er);
            if (pop) void'(exp_q.pop_front());
            if (ew) begin
                chk("wr_mem_req", {mem_req, mem_we}, 2'b11);
                chk("wr_mem_addr", mem_addr, wr_addr);
                chk("wr_mem_be", mem_be, wr_be);
                chk("wr_mem_wdata", mem_wdata, wr_data);
                if (rd_req && ok && starve_m < SL) starve_m++;
                ref_mem[wr_addr[7:0]] = merge(ref_mem[wr_addr[7:0]], wr_data, wr_be);
            end else if (er) begin
                chk("rd_mem_req", {mem_req, mem_we}, 2'b10);
                chk("rd_mem_addr", mem_addr, rd_addr);
                chk("rd_mem_be", mem_be, {BW{1'b1}});
                exp_q.push_back('{data: ref_mem[rd_addr[7:0]], avail: cyc + 2});
                starve_m = 0;
                gnt_count++;
            end else begin
                chk("idle_mem", {mem_req, mem_we, mem_be, mem_addr, mem_wdata}, 0);
            end
        end
    end

    // Requester tasks: called and returning at the drive point (1 after posedge).
    task automatic do_write(input int a, input logic [BW-1:0] be, input logic [DW-1:0] d);
        wr_req = 1'b1; wr_addr = AW'(a); wr_be = be; wr_data = d;
        for (int n = 0; ; n++) begin
            @(negedge clk);
            if (wr_gnt) break;
            if (n > 200) begin
                checks++; errors++;
                $display("FAIL wr_timeout cyc=%0d actual=no_grant required=grant", cyc);
                break;
            end
        end
        @(posedge clk); #1;
        wr_req = 1'b0; wr_addr = '0; wr_be = '0; wr_data = '0;
    endtask

    task automatic do_read(input int a);
        rd_req = 1'b1; rd_addr = AW'(a);
        for (int n = 0; ; n++) begin
            @(negedge clk);
            if (rd_gnt) break;
            if (n > 200) begin
                checks++; errors++;
                $display("FAIL rd_timeout cyc=%0d actual=no_grant required=grant", cyc);
                break;
            end
        end
        @(posedge clk); #1;
        rd_req = 1'b0; rd_addr = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    bit wdone, rdone;
    int t0;

    initial begin
        for (int i = 0; i < 256; i++) begin sram[i] = '0; ref_mem[i] = '0; end
        mem_rdata = '0;
        rst = 1'b1; rd_rready = 1'b1;
        wr_req = 0; wr_addr = '0; wr_be = '0; wr_data = '0;
        rd_req = 0; rd_addr = '0;
        idle(3);
        rst = 1'b0;

        // Basic write then read back.
        do_write(32'h10, 8'hFF, 64'hDEADBEEF_CAFEF00D);
        do_read(32'h10);
        idle(4);
        $display("basic write/read done cyc=%0d", cyc);

        // Both requesters saturated: 4 writes, 1 forced read, repeating.
        fork
            for (int i = 0; i < 16; i++) do_write(32'h30 + (i % 4), 8'hFF, {$urandom, $urandom});
            for (int i = 0; i < 3; i++) do_read(32'h30 + i);
        join
        idle(4);
        $display("starvation phase done cyc=%0d", cyc);

        // Backpressure: only two reads may be granted while rready is low.
        for (int i = 0; i < 5; i++) do_write(i, 8'hFF, {$urandom, $urandom});
        rd_rready = 1'b0;
        gnt_count = 0;
        fork
            for (int i = 0; i < 5; i++) do_read(i);
            begin
                idle(10);
                chk("stall_grants", gnt_count, 2);
                rd_rready = 1'b1;
            end
        join
        idle(4);
        $display("backpressure phase done cyc=%0d", cyc);

        // Same-address write and read issued together.
        fork
            do_write(32'h40, 8'hFF, {$urandom, $urandom});
            do_read(32'h40);
        join
        idle(4);
        $display("same-address phase done cyc=%0d", cyc);

        // Reset in the cycle after a read grant drops that read.
        do_read(32'h10);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        do_read(32'h10);
        idle(4);
        $display("reset-drop phase done cyc=%0d", cyc);

        // Partial write.
        do_write(32'h20, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
        do_write(32'h20, 8'h0F, 64'h0);
        do_read(32'h20);
        idle(4);
        $display("partial write phase done cyc=%0d", cyc);

        // Throughput: back-to-back reads, one grant per cycle.
        gnt_count = 0;
        t0 = cyc;
        for (int i = 0; i < 8; i++) do_read(i);
        chk("tput_cycles", cyc - t0, 8);
        chk("tput_grants", gnt_count, 8);
        idle(4);
        $display("throughput phase done cyc=%0d", cyc);

        // Randomised traffic with random backpressure.
        wdone = 0; rdone = 0;
        fork
            begin
                repeat (150) begin
                    if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
                    do_write($urandom_range(0, 15), 8'($urandom), {$urandom, $urandom});
                end
                wdone = 1;
            end
            begin
                repeat (150) begin
                    if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
                    do_read($urandom_range(0, 15));
                end
                rdone = 1;
            end
            begin
                while (!(wdone && rdone)) begin
                    @(posedge clk); #1;
                    rd_rready = ($urandom_range(0, 3) != 0);
                end
                rd_rready = 1'b1;
            end
        join
        idle(6);
        chk("drain_empty", exp_q.size(), 0);
        $display("random phase done cyc=%0d", cyc);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
